// File: rtl/pdm_pkg.sv
// Shared constants and the shift-then-saturate helper used by the CIC output
// stage and the optional DC blocker (PDM_DCBLOCK_EN).
package pdm_pkg;
  localparam int ORDER_MAX = 5;
  localparam int ACC_W_DEF = 24;
  localparam int OUT_W_DEF = 16;
  localparam int SAT_W     = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Arithmetic right shift followed by clipping to a signed ow-bit range.
  function automatic sat_res_t shift_sat(input logic signed [SAT_W-1:0] x,
                                         input logic [4:0] sh,
                                         input int unsigned ow);
    logic signed [SAT_W-1:0] y, hi, lo;
    sat_res_t r;
    y     = x >>> sh;
    hi    = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.sat = 1'b0;
    r.val = y;
    if (y > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (y < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction
endpackage

// File: rtl/pdm_cic_comb.sv
// One CIC comb stage: out = in - previous in, advanced only by a valid token.
module pdm_cic_comb
  import pdm_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_vld,
  input  logic [ACC_W-1:0] in_data,
  output logic             out_vld,
  output logic [ACC_W-1:0] out_data
);
  logic [ACC_W-1:0] dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      dly_q    <= '0;
    end else if (!en) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      dly_q    <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_data <= in_data - dly_q;
        dly_q    <= in_data;
      end
    end
  end
endmodule

// File: rtl/pdm_cic_decim.sv
// PDM-to-PCM CIC decimator: PDM-rate integrators, pipelined PCM-rate combs,
// shift/saturate output with warm-up suppression. Optional PDM_DCBLOCK_EN.
module pdm_cic_decim
  import pdm_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DC_K  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ce_pdm,
  input  logic             pdm_in,
  input  logic             ce_pcm,
  input  logic [4:0]       shift,
  input  logic             clr_sat,
  output logic [OUT_W-1:0] pcm_data,
  output logic             pcm_valid,
  output logic             sat_flag
);
  localparam logic [2:0] WARM_N = 3'(ORDER);

  logic [ACC_W-1:0]              x;
  logic [ORDER-1:0][ACC_W-1:0]   integ_q, integ_d;
  logic [ORDER:0][ACC_W-1:0]     data_pipe;
  logic [ORDER:0]                vld_pipe;
  logic [2:0]                    warm_q;
  logic                          primed, fire, st_vld;
  logic [OUT_W-1:0]              st_data;
  logic signed [SAT_W-1:0]       comb_sx;
  sat_res_t                      res;

  assign x = pdm_in ? ACC_W'(1) : '1;

  // Integrator cascade: each stage adds the freshly updated previous stage.
  always_comb begin
    logic [ACC_W-1:0] acc;
    integ_d = '0;
    acc     = x;
    for (int k = 0; k < ORDER; k++) begin
      acc        = acc + integ_q[k];
      integ_d[k] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       integ_q <= '0;
    else if (!en)     integ_q <= '0;
    else if (ce_pdm)  integ_q <= integ_d;
  end

  // Registered integrator output is sampled, so a coincident ce_pdm is not seen.
  assign data_pipe[0] = integ_q[ORDER-1];
  assign vld_pipe[0]  = ce_pcm && en;

  for (genvar g = 0; g < ORDER; g++) begin : g_comb
    pdm_cic_comb #(.ACC_W(ACC_W)) u_comb (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .in_vld   (vld_pipe[g]),
      .in_data  (data_pipe[g]),
      .out_vld  (vld_pipe[g+1]),
      .out_data (data_pipe[g+1])
    );
  end

  assign comb_sx = SAT_W'($signed(data_pipe[ORDER]));
  assign res     = shift_sat(comb_sx, shift, OUT_W);
  assign primed  = (warm_q == WARM_N);
  assign fire    = en && vld_pipe[ORDER] && primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q   <= '0;
      st_vld   <= 1'b0;
      st_data  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (fire && res.sat) sat_flag <= 1'b1;
      else if (clr_sat)    sat_flag <= 1'b0;
      if (!en) begin
        warm_q <= '0;
        st_vld <= 1'b0;
      end else begin
        st_vld <= fire;
        if (vld_pipe[ORDER] && !primed) warm_q <= warm_q + 3'd1;
        if (fire) st_data <= res.val[OUT_W-1:0];
      end
    end
  end

`ifdef PDM_DCBLOCK_EN
  localparam int DC_AW = OUT_W + DC_K;

  logic [OUT_W-1:0]        dc_xp_q;
  logic [DC_AW-1:0]        dc_acc_q;
  logic signed [SAT_W-1:0] dc_x, dc_xp, dc_acc, dc_nxt;
  sat_res_t                dc_acc_sat, dc_out_sat;

  // Accumulator holds y scaled by 2^DC_K so the leak reaches zero.
  assign dc_x       = SAT_W'($signed(st_data));
  assign dc_xp      = SAT_W'($signed(dc_xp_q));
  assign dc_acc     = SAT_W'($signed(dc_acc_q));
  assign dc_nxt     = dc_acc + ((dc_x - dc_xp) <<< DC_K) - (dc_acc >>> DC_K);
  assign dc_acc_sat = shift_sat(dc_nxt, 5'd0, DC_AW);
  assign dc_out_sat = shift_sat(dc_nxt, 5'(DC_K), OUT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_xp_q   <= '0;
      dc_acc_q  <= '0;
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
    end else if (!en) begin
      dc_xp_q   <= '0;
      dc_acc_q  <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= st_vld;
      if (st_vld) begin
        dc_xp_q  <= st_data;
        dc_acc_q <= dc_acc_sat.val[DC_AW-1:0];
        pcm_data <= dc_out_sat.val[OUT_W-1:0];
      end
    end
  end
`else
  wire [DC_K-1:0] dc_k_unused = '0;
  assign pcm_data  = st_data;
  assign pcm_valid = st_vld;
`endif
endmodule

// File: tb/tb_pdm_cic_decim.sv
// Self-checking bench for pdm_cic_decim: constant vector table, hand sequences
// and random stimulus against a decimated-history CIC reference model.
module tb_pdm_cic_decim;
  localparam int ORDER = 3;
  localparam int ACC_W = 24;
  localparam int OUT_W = 16;
  localparam int LAT   = ORDER + 1;

  logic        clk = 1'b0;
  logic        rst_n, en, ce_pdm, pdm_in, ce_pcm, clr_sat;
  logic [4:0]  shift;
  logic [15:0] pcm_data;
  logic        pcm_valid, sat_flag;

  pdm_cic_decim #(.ORDER(ORDER), .ACC_W(ACC_W), .OUT_W(OUT_W), .DC_K(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ce_pdm(ce_pdm), .pdm_in(pdm_in),
    .ce_pcm(ce_pcm), .shift(shift), .clr_sat(clr_sat),
    .pcm_data(pcm_data), .pcm_valid(pcm_valid), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int due; longint data; bit clip; } tok_t;
  typedef struct { int mode; logic [4:0] sh; longint exp_data; bit exp_sat; } vec_t;

  longint mi[3];
  longint h1, h2, h3;
  int     ncap, cyc, nvalid;
  bit     sat_exp;
  longint last_data;
  tok_t   sb[$];
  int     errors = 0, checks = 0;

  function automatic longint wrap(input longint v);
    longint m;
    m = (longint'(1) <<< ACC_W) - 1;
    v = v & m;
    return (v >= (longint'(1) <<< (ACC_W - 1))) ? v - (longint'(1) <<< ACC_W) : v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) mi[k] = 0;
    h1 = 0; h2 = 0; h3 = 0; ncap = 0;
    sb.delete();
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit p_ce_pdm, input bit p_pdm, input bit p_ce_pcm, input bit p_clr);
    longint v, d, y;
    bit c, exp_v;
    tok_t t;
    ce_pdm = p_ce_pdm; pdm_in = p_pdm; ce_pcm = p_ce_pcm; clr_sat = p_clr;
    if (!en) model_clear();
    else begin
      if (p_ce_pcm) begin
        v = mi[2];
        d = wrap(v - 3 * h1 + 3 * h2 - h3);
        y = d >>> shift;
        c = 1'b0;
        if (y > 32767) begin y = 32767; c = 1'b1; end
        else if (y < -32768) begin y = -32768; c = 1'b1; end
        if (ncap >= ORDER) sb.push_back('{cyc + LAT, y, c});
        h3 = h2; h2 = h1; h1 = v; ncap++;
      end
      if (p_ce_pdm) begin
        mi[0] = wrap(mi[0] + (p_pdm ? 1 : -1));
        mi[1] = wrap(mi[1] + mi[0]);
        mi[2] = wrap(mi[2] + mi[1]);
      end
    end
    @(posedge clk); #1; cyc++;
    exp_v = 1'b0;
    t = '{0, 0, 1'b0};
    if (sb.size() > 0 && sb[0].due == cyc) begin exp_v = 1'b1; t = sb.pop_front(); end
    if (exp_v && t.clip) sat_exp = 1'b1;
    else if (p_clr)      sat_exp = 1'b0;
    chk("pcm_valid", pcm_valid, exp_v);
    if (exp_v) begin
      chk("pcm_data", $signed(pcm_data), t.data);
      last_data = $signed(pcm_data);
      nvalid++;
    end
    chk("sat_flag", sat_flag, sat_exp);
  endtask

  task automatic en_pulse();
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    nvalid = 0;
  endtask

  // mode 0: all zeros, 1: all ones, 2: alternating 0,1
  task automatic run_pattern(input int mode, input int ncyc);
    int k;
    bit b;
    k = 0;
    for (int p = 0; p < ncyc; p++) begin
      b = (mode == 1) ? 1'b1 : (mode == 2) ? k[0] : 1'b0;
      if (p % 5 == 0) k++;
      step(p % 5 == 0, b, p % 320 == 0, 1'b0);
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   c0, lat;
    longint cd;
    tbl[0] = '{1, 5'd4,  16384,  1'b0};
    tbl[1] = '{0, 5'd4,  -16384, 1'b0};
    tbl[2] = '{2, 5'd4,  0,      1'b0};
    tbl[3] = '{1, 5'd0,  32767,  1'b1};
    tbl[4] = '{0, 5'd0,  -32768, 1'b1};
    tbl[5] = '{1, 5'd24, 0,      1'b0};
    tbl[6] = '{0, 5'd31, -1,     1'b0};

    rst_n = 1'b0; en = 1'b0; ce_pdm = 1'b0; pdm_in = 1'b0; ce_pcm = 1'b0;
    clr_sat = 1'b0; shift = 5'd4;
    cyc = 0; nvalid = 0; sat_exp = 1'b0; last_data = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", $signed(pcm_data), 0);
    chk("reset_valid", pcm_valid, 0);
    chk("reset_sat", sat_flag, 0);
    rst_n = 1'b1; en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      shift = tbl[i].sh;
      en_pulse();
      run_pattern(tbl[i].mode, 8 * 320);
      chk("vec_data", last_data, tbl[i].exp_data);
      chk("vec_nvalid", nvalid, 5);
      chk("vec_sat", sat_flag, tbl[i].exp_sat);
    end

    // sat_flag: clr_sat clears; a clip in the same clk wins over clr_sat
    shift = 5'd0;
    en_pulse();
    run_pattern(1, 5 * 320);
    chk("sat_set", sat_flag, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("sat_cleared", sat_flag, 0);
    for (int p = 0; p < 330; p++) begin
      step(p % 5 == 0, 1'b1, p == 0, p == 3);
      if (p == 3) begin
        chk("clip_vs_clr_valid", pcm_valid, 1);
        chk("clip_vs_clr_sat", sat_flag, 1);
      end
    end

    // Latency and coincident ce_pcm/ce_pdm capture (pre-update value = 1)
    en_pulse();
    for (int i = 0; i < ORDER; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    c0 = cyc;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    lat = -1; cd = 0;
    for (int i = 0; i < 8; i++) begin
      if (pcm_valid && lat < 0) begin lat = cyc - c0; cd = $signed(pcm_data); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("latency", lat, 4);
    chk("coincident_data", cd, 1);

    // Asynchronous reset with a token in flight
    shift = 5'd4;
    en_pulse();
    run_pattern(1, 5 * 320 + 2);
    chk("pre_reset_data", $signed(pcm_data), 16384);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_data", $signed(pcm_data), 0);
    chk("rst_async_valid", pcm_valid, 0);
    chk("rst_async_sat", sat_flag, 0);
    model_clear(); sat_exp = 1'b0; last_data = 0;
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1;
    nvalid = 0;
    run_pattern(1, 8 * 320);
    chk("post_reset_nvalid", nvalid, 5);
    chk("post_reset_data", last_data, 16384);

    // Random stimulus against the model
    for (int r = 0; r < 3; r++) begin
      shift = 5'($urandom_range(0, 14));
      en_pulse();
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 1499) == 0) en_pulse();
        step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
